// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU memory-side blocks.
// Holds the arbiter state encoding, bus-owner codes and the default boot address.
// Imported by cpu_mem_arbiter; carries no logic of its own.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_LS = 1'b1;

  localparam logic [31:0] BOOT_ADDRESS = 32'h0000_0000;

endpackage

// File: rtl/cpu_mem_arbiter.sv
// Shares one 32-bit memory port between instruction fetch (IF) and load/store (LS).
// Ports: clk_i/rst_i; IF request/flush/ack/data/stall; LS request/we/be/addr/wdata/ack/data;
//        err_o timeout flag; mem_* bus master side with mem_ack_i/mem_rdata_i completion.
// Latency: request sampled in IDLE -> ack 3 cycles later with a first-cycle bus ack.
// Backpressure: requests are levels held until ack; if_stall_o is the only combinational output.
module cpu_mem_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned LS_STREAK_MAX  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  output logic        if_ack_o,
  output logic [31:0] if_data_o,
  output logic        if_stall_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [3:0]  ls_be_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_ack_o,
  output logic [31:0] ls_data_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [3:0] STREAK_MAX = 4'(LS_STREAK_MAX);
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic       TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  arb_state_t  state_q, state_d;
  logic        owner_q, owner_d;
  logic        drop_q, drop_d;
  logic        timed_out_q, timed_out_d;
  logic [7:0]  timer_q, timer_d;
  logic [3:0]  streak_q, streak_d;
  logic [31:0] resp_data_q, resp_data_d;

  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        if_ack_q, if_ack_d;
  logic [31:0] if_data_q, if_data_d;
  logic        ls_ack_q, ls_ack_d;
  logic [31:0] ls_data_q, ls_data_d;
  logic        err_q, err_d;

  logic        is_idle;
  logic        grant_if;
  logic        grant_ls;
  logic        timeout_hit;

  // A flushing fetch is never granted; once LS has won STREAK_MAX times in a
  // row while IF waited, IF takes the next contended slot.
  assign is_idle     = (state_q == ST_IDLE);
  assign grant_if    = is_idle & if_req_i & ~if_flush_i & (~ls_req_i | (streak_q >= STREAK_MAX));
  assign grant_ls    = is_idle & ls_req_i & ~grant_if;
  assign timeout_hit = TIMEOUT_EN & (timer_q == TIMER_LAST) & ~mem_ack_i;

  assign if_stall_o  = if_req_i & ~((state_q == ST_BUSY) & (owner_q == OWNER_IF));

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_ack_o    = if_ack_q;
  assign if_data_o   = if_data_q;
  assign ls_ack_o    = ls_ack_q;
  assign ls_data_o   = ls_data_q;
  assign err_o       = err_q;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    drop_d      = drop_q;
    timed_out_d = timed_out_q;
    timer_d     = timer_q;
    streak_d    = streak_q;
    resp_data_d = resp_data_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    ls_ack_d    = 1'b0;
    err_d       = 1'b0;
    if_data_d   = if_data_q;
    ls_data_d   = ls_data_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_if || grant_ls) begin
          state_d     = ST_BUSY;
          mem_req_d   = 1'b1;
          timer_d     = 8'd0;
          timed_out_d = 1'b0;
          drop_d      = 1'b0;
        end
        if (grant_if) begin
          owner_d     = OWNER_IF;
          mem_we_d    = 1'b0;
          mem_be_d    = 4'hF;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = 32'd0;
          streak_d    = 4'd0;
        end else if (grant_ls) begin
          owner_d     = OWNER_LS;
          mem_we_d    = ls_we_i;
          mem_be_d    = ls_be_i;
          mem_addr_d  = ls_addr_i;
          mem_wdata_d = ls_wdata_i;
          // The streak only measures LS wins that actually made IF wait.
          if (!if_req_i) begin
            streak_d = 4'd0;
          end else if (streak_q < STREAK_MAX) begin
            streak_d = streak_q + 4'd1;
          end
        end
      end

      ST_BUSY: begin
        timer_d = timer_q + 8'd1;
        // The bus cycle runs to completion; a flush only marks the result as stale.
        if (if_flush_i && (owner_q == OWNER_IF)) begin
          drop_d = 1'b1;
        end
        if (mem_ack_i) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          resp_data_d = mem_rdata_i;
          state_d     = ST_RESP;
        end else if (timeout_hit) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          resp_data_d = 32'd0;
          timed_out_d = 1'b1;
          state_d     = ST_RESP;
        end
      end

      ST_RESP: begin
        if (owner_q == OWNER_LS) begin
          ls_ack_d  = 1'b1;
          ls_data_d = resp_data_q;
          err_d     = timed_out_q;
        end else if (!drop_q) begin
          if_ack_d  = 1'b1;
          if_data_d = resp_data_q;
          err_d     = timed_out_q;
        end
        drop_d      = 1'b0;
        timer_d     = 8'd0;
        timed_out_d = 1'b0;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWNER_IF;
      drop_q      <= 1'b0;
      timed_out_q <= 1'b0;
      timer_q     <= 8'd0;
      streak_q    <= 4'd0;
      resp_data_q <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      if_ack_q    <= 1'b0;
      if_data_q   <= 32'd0;
      ls_ack_q    <= 1'b0;
      ls_data_q   <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      drop_q      <= drop_d;
      timed_out_q <= timed_out_d;
      timer_q     <= timer_d;
      streak_q    <= streak_d;
      resp_data_q <= resp_data_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      if_data_q   <= if_data_d;
      ls_ack_q    <= ls_ack_d;
      ls_data_q   <= ls_data_d;
      err_q       <= err_d;
    end
  end

endmodule
